mem_port_arbiter: RTL

- Shares one single-ported memory between the pipeline's instruction-fetch (IF) stage and data-memory (DM) stage.
- Grants the port to one requester at a time and sequences a req/ack transaction to the memory.
- Returns read data with a one-cycle valid pulse, and stalls the losing or waiting requester.
- Sits between the pipelined datapath's IF/MEM stages and the unified memory model; its stall outputs feed the hazard logic that freezes PC and pipeline registers.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF/DM requester and unified-memory signals around mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          dm_stall;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata, m_ack,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata, m_ack,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the IF and DM pipeline stages.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back DM grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

    state_e state;
    logic   cooldown;
    logic   grant_dm;
    logic   grant_if;

    // A valid pulse marks the one idle cycle after a completion; no arbitration then.
    assign cooldown = bus.if_valid | bus.dm_valid;

    assign bus.if_stall = bus.if_req & ~bus.if_valid;
    assign bus.dm_stall = bus.dm_req & ~bus.dm_valid;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign grant_dm = bus.dm_req & ~(bus.if_req & (starve_cnt == 4'(STARVE_LIMIT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == StIdle) begin
            if (!bus.if_req) begin
                starve_cnt <= '0;
            end else if (!cooldown) begin
                if (grant_dm) starve_cnt <= starve_cnt + 4'd1;
                else          starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_dm = bus.dm_req;
`endif

    assign grant_if = bus.if_req & ~grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            bus.m_req    <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.if_rdata <= '0;
            bus.if_valid <= 1'b0;
            bus.dm_rdata <= '0;
            bus.dm_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    bus.if_valid <= 1'b0;
                    bus.dm_valid <= 1'b0;
                    if (!cooldown && grant_dm) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.dm_we;
                        bus.m_addr  <= bus.dm_addr;
                        bus.m_wdata <= bus.dm_wdata;
                        state       <= StDmBusy;
                    end else if (!cooldown && grant_if) begin
                        bus.m_req  <= 1'b1;
                        bus.m_we   <= 1'b0;
                        bus.m_addr <= bus.if_addr;
                        state      <= StIfBusy;
                    end
                end
                StIfBusy: begin
                    if (bus.m_ack) begin
                        bus.m_req    <= 1'b0;
                        bus.if_rdata <= bus.m_rdata;
                        bus.if_valid <= 1'b1;
                        state        <= StIdle;
                    end
                end
                StDmBusy: begin
                    if (bus.m_ack) begin
                        bus.m_req    <= 1'b0;
                        if (!bus.m_we) bus.dm_rdata <= bus.m_rdata;
                        bus.dm_valid <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
